// File: rtl/fib_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_gen
// Brief    : Fibonacci instruction sequencer (MOVI/MOV/ADD) with a lock-step
//            shadow register file, sticky overflow and 7-segment result glyph.
// Revision : 1.0  initial release
// ============================================================================
module fib_seq_gen #(
    parameter  int WIDTH    = 16,
    parameter  int NUM_REGS = 16,
    localparam int NW       = $clog2(NUM_REGS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NW-1:0]    n_terms,
    output logic [15:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [WIDTH-1:0] result,
    input  logic [3:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [6:0]       display
);

    localparam logic [NW-1:0] c_N_MIN = NW'(2);
    localparam logic [NW-1:0] c_N_MAX = NW'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT0 = 3'd1,
        S_INIT1 = 3'd2,
        S_COPY  = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    logic [NW-1:0]    r_n;
    logic [3:0]       r_k;
    logic [15:0]      r_instr;
    logic             r_instr_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_regs [NUM_REGS];

    logic             w_fire;
    logic [3:0]       w_km1;
    logic [3:0]       w_km2;
    logic [3:0]       w_kp1;
    logic [WIDTH:0]   w_sum;
    logic             w_last;
    logic             w_n_gt2;
    logic [NW-1:0]    w_n_clamp;
    logic [6:0]       w_display;

    function automatic logic [15:0] f_movi(input logic [3:0] rd);
        return {4'hD, rd, 8'h01};
    endfunction

    function automatic logic [15:0] f_mov(input logic [3:0] rd, input logic [3:0] rs);
        return {4'h0, rd, 4'hD, rs};
    endfunction

    function automatic logic [15:0] f_add(input logic [3:0] rd, input logic [3:0] rs);
        return {4'h0, rd, 4'h5, rs};
    endfunction

    assign w_fire  = r_instr_valid & instr_ready;
    assign w_km1   = r_k - 4'd1;
    assign w_km2   = r_k - 4'd2;
    assign w_kp1   = r_k + 4'd1;
    // In ACC r[k] already holds the copy of r[k-2], so this is F(k-2)+F(k-1).
    assign w_sum   = {1'b0, r_regs[r_k]} + {1'b0, r_regs[w_km1]};
    assign w_last  = ((32'(r_k) + 32'd1) == 32'(r_n));
    assign w_n_gt2 = (32'(r_n) > 32'd2);

    always_comb begin
        w_n_clamp = n_terms;
        if (32'(n_terms) < 32'd2) begin
            w_n_clamp = c_N_MIN;
        end else if (32'(n_terms) > 32'(NUM_REGS)) begin
            w_n_clamp = c_N_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_n           <= c_N_MIN;
            r_k           <= 4'd0;
            r_instr       <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_result      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_n           <= w_n_clamp;
                        r_k           <= 4'd0;
                        r_done        <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_result      <= '0;
                        r_busy        <= 1'b1;
                        r_instr       <= f_movi(4'd0);
                        r_instr_valid <= 1'b1;
                        r_state       <= S_INIT0;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            r_regs[i] <= '0;
                        end
                    end
                end
                S_INIT0: begin
                    if (w_fire) begin
                        r_regs[0] <= WIDTH'(1);
                        r_instr   <= f_movi(4'd1);
                        r_state   <= S_INIT1;
                    end
                end
                S_INIT1: begin
                    if (w_fire) begin
                        r_regs[1] <= WIDTH'(1);
                        r_k       <= 4'd2;
                        if (w_n_gt2) begin
                            r_instr <= f_mov(4'd2, 4'd0);
                            r_state <= S_COPY;
                        end else begin
                            r_instr_valid <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_result      <= WIDTH'(1);
                            r_state       <= S_DONE;
                        end
                    end
                end
                S_COPY: begin
                    if (w_fire) begin
                        r_regs[r_k] <= r_regs[w_km2];
                        r_instr     <= f_add(r_k, w_km1);
                        r_state     <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_fire) begin
                        r_regs[r_k] <= w_sum[WIDTH-1:0];
                        r_overflow  <= r_overflow | w_sum[WIDTH];
                        if (w_last) begin
                            // The final sum lands in r[n-1] on this same edge.
                            r_instr_valid <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_result      <= w_sum[WIDTH-1:0];
                            r_state       <= S_DONE;
                        end else begin
                            r_k     <= w_kp1;
                            r_instr <= f_mov(w_kp1, w_km1);
                            r_state <= S_COPY;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (NUM_REGS == 16) begin : g_rd_full
            assign rd_data = r_regs[rd_addr];
        end else begin : g_rd_range
            assign rd_data = (32'(rd_addr) < 32'(NUM_REGS)) ? r_regs[rd_addr] : '0;
        end
    endgenerate

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    always_comb begin
        w_display = 7'b1000000;
        case (r_result[3:0])
            4'h0: w_display = 7'b1000000;
            4'h1: w_display = 7'b1111001;
            4'h2: w_display = 7'b0100100;
            4'h3: w_display = 7'b0110000;
            4'h4: w_display = 7'b0011001;
            4'h5: w_display = 7'b0010010;
            4'h6: w_display = 7'b0000010;
            4'h7: w_display = 7'b1111000;
            4'h8: w_display = 7'b0000000;
            4'h9: w_display = 7'b0010000;
            4'hA: w_display = 7'b0001000;
            4'hB: w_display = 7'b0000011;
            4'hC: w_display = 7'b1000110;
            4'hD: w_display = 7'b0100001;
            4'hE: w_display = 7'b0000110;
            4'hF: w_display = 7'b0001110;
            default: w_display = 7'b1000000;
        endcase
    end

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign result      = r_result;
    assign display     = w_display;

endmodule
`default_nettype wire
